// File: rtl/if_fetch_pkg.sv
// Stall codes and fetch-state encodings shared with the stall controller.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    STALL_PASS = 2'b00,
    STALL_HOLD = 2'b01,
    STALL_BUBB = 2'b10
  } stall_code_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_DRAIN = 2'b01,
    ST_READY = 2'b10
  } fetch_state_e;

  localparam logic [2:0] LAST_BYTE = 3'd3;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch over a byte-wide memory port: issues 4 byte reads, assembles a
// little-endian word, presents it until the stall controller lets it pass.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall_reg_pc,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  output logic        mem_rd_en,
  output logic [31:0] mem_a,
  output logic        stall_if,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  inst_d;
  logic [2:0]   issue_cnt_q;
  logic [2:0]   recv_cnt_q;
  logic         flush_q;
  logic         pend_q;
  logic         issue;
  logic         accept;
  logic         advance;

  assign mem_rd_en = (state_q == ST_FETCH) && !br_en && !rst;
  assign mem_a     = pc_q + {29'd0, issue_cnt_q};
  assign issue     = mem_rd_en && mem_gnt;
  // A returning byte belongs to the current fetch only if its issue was granted and
  // no redirect or reset has intervened since.
  assign accept    = pend_q && !flush_q && !br_en && !rst;
  assign advance   = (state_q == ST_READY) && (stall_reg_pc == STALL_PASS);

  assign stall_if  = rst || (state_q != ST_READY);
  assign if_pc     = rst ? RESET_PC : pc_q;
  assign if_inst   = rst ? 32'd0 : inst_q;

  always_comb begin
    inst_d = inst_q;
    if (accept) begin
      inst_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      flush_q     <= 1'b1;
      pend_q      <= 1'b0;
      inst_q      <= 32'd0;
    end else begin
      pend_q  <= issue;
      flush_q <= br_en;
      inst_q  <= inst_d;
      if (br_en) begin
        pc_q        <= br_target;
        issue_cnt_q <= 3'd0;
        recv_cnt_q  <= 3'd0;
        state_q     <= ST_FETCH;
      end else begin
        if (issue) begin
          issue_cnt_q <= issue_cnt_q + 3'd1;
        end
        if (accept) begin
          recv_cnt_q <= recv_cnt_q + 3'd1;
        end
        case (state_q)
          ST_FETCH: if (issue && issue_cnt_q == LAST_BYTE) state_q <= ST_DRAIN;
          ST_DRAIN: if (accept && recv_cnt_q == LAST_BYTE) state_q <= ST_READY;
          ST_READY: begin
            // Hold and Bubb both keep the word on display.
            if (advance) begin
              pc_q        <= pc_q + 32'd4;
              issue_cnt_q <= 3'd0;
              recv_cnt_q  <= 3'd0;
              state_q     <= ST_FETCH;
            end
          end
          default: state_q <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed corner sequences, a vector table, then random traffic
// checked every cycle against a grant-counting reference model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  stall_reg_pc;
  logic        br_en;
  logic [31:0] br_target;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        mem_rd_en;
  logic [31:0] mem_a;
  logic        stall_if;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int tests = 0;
  int fails = 0;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_reg_pc(stall_reg_pc), .br_en(br_en),
    .br_target(br_target), .mem_gnt(mem_gnt), .mem_din(mem_din),
    .mem_rd_en(mem_rd_en), .mem_a(mem_a), .stall_if(stall_if),
    .if_pc(if_pc), .if_inst(if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w0;
    w0 = 32'h0000_0513;
    if (a < 32'd4) return 8'(w0 >> {a[1:0], 3'b000});
    return a[7:0] ^ a[31:24];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // Memory: one-cycle read latency; junk on the bus when nothing was issued.
  always @(posedge clk) begin
    mem_din <= (mem_rd_en && mem_gnt) ? mem_byte(mem_a) : 8'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is the 4 grants after its start; the word shows 2 cycles
  // after the 4th grant and is the memory word at the fetch PC.
  logic [31:0] m_pc = RESET_PC;
  int          m_n = 0;
  int          m_rdy_at = 0;
  int          cyc = 0;
  logic        m_ready;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      chk("mon_rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("mon_rst_stall_if", 32'(stall_if), 32'd1);
      chk("mon_rst_if_pc", if_pc, RESET_PC);
      chk("mon_rst_if_inst", if_inst, 32'd0);
      m_pc = RESET_PC;
      m_n  = 0;
    end else begin
      m_ready = (m_n == 4) && (cyc >= m_rdy_at);
      chk("mon_stall_if", 32'(stall_if), 32'(!m_ready));
      chk("mon_rd_en", 32'(mem_rd_en), 32'((m_n < 4) && !br_en));
      if (mem_rd_en && m_n < 4) chk("mon_mem_a", mem_a, m_pc + 32'(m_n));
      if (m_ready) begin
        chk("mon_if_pc", if_pc, m_pc);
        chk("mon_if_inst", if_inst, mem_word(m_pc));
      end
      if (br_en) begin
        m_pc = br_target;
        m_n  = 0;
      end else if (m_ready && stall_reg_pc == STALL_PASS) begin
        m_pc = m_pc + 32'd4;
        m_n  = 0;
      end else if (m_n < 4 && mem_gnt) begin
        m_n++;
        if (m_n == 4) m_rdy_at = cyc + 2;
      end
    end
  end

  // Called just after sampling; returns just after sampling the ready cycle.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (stall_if && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(stall_if), 32'd0);
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic [7:0]  gnt_pat;
    logic [31:0] exp_inst;
    int          exp_lat;
  } vec_t;

  vec_t vt[5];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic rdy;

    vt[0] = '{32'h0000_0100, 8'hFF, 32'h0302_0100, 6};
    vt[1] = '{32'h0000_0103, 8'hF9, 32'h0605_0403, 8};
    vt[2] = '{32'hFFFF_FFFE, 8'hFF, 32'h0513_0001, 6};
    vt[3] = '{32'h8000_0010, 8'hF5, 32'h9392_9190, 8};
    vt[4] = '{32'h0000_0000, 8'hFF, 32'h0000_0513, 6};

    rst = 1'b1; stall_reg_pc = STALL_HOLD; br_en = 1'b0; br_target = 32'd0; mem_gnt = 1'b1;

    // Reset, then first fetch from 0 with continuous grant.
    @(negedge clk); #1;
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_stall_if", 32'(stall_if), 32'd1);
    chk("rst_if_pc", if_pc, RESET_PC);
    chk("rst_if_inst", if_inst, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k == 0) begin
        chk("post_rst_if_pc", if_pc, RESET_PC);
        chk("post_rst_if_inst", if_inst, 32'd0);
      end
      if (k < 4) begin
        chk("first_mem_a", mem_a, 32'(k));
        chk("first_rd_en", 32'(mem_rd_en), 32'd1);
      end
      if (k < 5) chk("first_stall_hi", 32'(stall_if), 32'd1);
      if (k == 5) begin
        chk("first_stall_lo", 32'(stall_if), 32'd0);
        chk("first_inst", if_inst, 32'h0000_0513);
        chk("first_pc", if_pc, 32'd0);
      end
      @(negedge clk);
    end

    // Hold for 3 more cycles, then Pass.
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_inst", if_inst, 32'h0000_0513);
      chk("hold_pc", if_pc, 32'd0);
      chk("hold_rd_en", 32'(mem_rd_en), 32'd0);
      @(negedge clk);
    end
    stall_reg_pc = STALL_PASS; #1;
    @(negedge clk); stall_reg_pc = STALL_HOLD; #1;
    chk("pass_mem_a", mem_a, 32'h4);
    chk("pass_rd_en", 32'(mem_rd_en), 32'd1);

    // Redirect while byte 2 (addr 6) is in flight.
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); br_en = 1'b1; br_target = 32'h100; #1;
    chk("br_rd_en_suppressed", 32'(mem_rd_en), 32'd0);
    @(negedge clk); br_en = 1'b0; #1;
    chk("br_mem_a", mem_a, 32'h100);
    wait_ready("br_ready");
    chk("br_inst", if_inst, 32'h0302_0100);
    chk("br_pc", if_pc, 32'h100);

    // Redirect coincident with Pass.
    @(negedge clk); stall_reg_pc = STALL_PASS; br_en = 1'b1; br_target = 32'h2F0; #1;
    @(negedge clk); br_en = 1'b0; stall_reg_pc = STALL_HOLD; #1;
    chk("br_pass_mem_a", mem_a, 32'h2F0);
    wait_ready("br_pass_ready");
    chk("br_pass_inst", if_inst, 32'hF3F2_F1F0);
    chk("br_pass_pc", if_pc, 32'h2F0);

    // Reset while the last byte is outstanding.
    @(negedge clk); stall_reg_pc = STALL_PASS; #1;
    @(negedge clk); stall_reg_pc = STALL_HOLD; #1;
    chk("drain_fetch_a0", mem_a, 32'h2F4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); rst = 1'b1; #1;
    chk("drain_rst_stall_if", 32'(stall_if), 32'd1);
    chk("drain_rst_rd_en", 32'(mem_rd_en), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("drain_restart_a", mem_a, RESET_PC);
    chk("drain_restart_rd_en", 32'(mem_rd_en), 32'd1);
    chk("drain_restart_stall", 32'(stall_if), 32'd1);
    chk("drain_restart_pc", if_pc, RESET_PC);
    wait_ready("drain_ready");
    chk("drain_inst", if_inst, 32'h0000_0513);

    // Vector table: redirect, grant pattern per fetch cycle, latency and word.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); br_en = 1'b1; br_target = vt[i].tgt; mem_gnt = 1'b1;
      n = 0; rdy = 1'b0;
      while (!rdy && n < 20) begin
        @(negedge clk);
        br_en = 1'b0;
        mem_gnt = (n < 8) ? vt[i].gnt_pat[n] : 1'b1;
        n++;
        #1;
        if (!stall_if) rdy = 1'b1;
      end
      chk("vec_latency", 32'(n), 32'(vt[i].exp_lat));
      chk("vec_pc", if_pc, vt[i].tgt);
      chk("vec_inst", if_inst, vt[i].exp_inst);
    end

    // Random traffic; the monitor model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 255) == 0);
      br_en        = !rst && ($urandom_range(0, 15) == 0);
      br_target    = $urandom_range(0, 1) ? 32'($urandom) : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
      mem_gnt      = ($urandom_range(0, 3) != 0);
      stall_reg_pc = 2'($urandom_range(0, 2));
    end

    @(negedge clk);
    rst = 1'b0; br_en = 1'b0; stall_reg_pc = STALL_HOLD;
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
